// File: rtl/fifo_cntl_ext.sv
// Single-clock FIFO controller for an external dual-port RAM: wrapping pointers,
// occupancy count, almost-full/empty thresholds, optional bypass, flush and sticky errors.
module fifo_cntl_ext #(
  parameter int unsigned NUM_ENTRIES   = 16,
  parameter bit          BYPASS_EN     = 1'b1,
  parameter int unsigned AFULL_THRESH  = 14,
  parameter int unsigned AEMPTY_THRESH = 2,
  localparam int unsigned AW = $clog2(NUM_ENTRIES),
  localparam int unsigned CW = $clog2(NUM_ENTRIES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic          err_clr,
  output logic          we,
  output logic          bypass,
  output logic [AW-1:0] waddr_ff,
  output logic [AW-1:0] raddr_ff,
  output logic [CW-1:0] count_ff,
  output logic          full_ff,
  output logic          empty_ff,
  output logic          afull_ff,
  output logic          aempty_ff,
  output logic          overflow_ff,
  output logic          underflow_ff
);

  logic          wr;
  logic          rd;
  logic          ovf_set;
  logic          unf_set;
  logic [CW-1:0] count_nxt;

  // Pointers wrap at NUM_ENTRIES so non-power-of-two depths stay in range.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(NUM_ENTRIES - 1)) ? '0 : p + AW'(1);
  endfunction

  assign bypass  = BYPASS_EN & push & pop & empty_ff & ~flush;
  assign wr      = push & ~full_ff & ~bypass & ~flush;
  assign rd      = pop & ~empty_ff & ~flush;
  assign we      = wr;
  assign ovf_set = push & full_ff;
  assign unf_set = pop & empty_ff & ~bypass;

  always_comb begin
    count_nxt = count_ff;
    if (flush)          count_nxt = '0;
    else if (wr && !rd) count_nxt = count_ff + CW'(1);
    else if (rd && !wr) count_nxt = count_ff - CW'(1);
  end

  // Pointers, count and occupancy flags; flags derive from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_ff  <= '0;
      raddr_ff  <= '0;
      count_ff  <= '0;
      full_ff   <= 1'b0;
      empty_ff  <= 1'b1;
      afull_ff  <= 1'b0;
      aempty_ff <= 1'b1;
    end else begin
      if (flush) begin
        waddr_ff <= '0;
        raddr_ff <= '0;
      end else begin
        if (wr) waddr_ff <= ptr_inc(waddr_ff);
        if (rd) raddr_ff <= ptr_inc(raddr_ff);
      end
      count_ff  <= count_nxt;
      full_ff   <= (count_nxt == CW'(NUM_ENTRIES));
      empty_ff  <= (count_nxt == '0);
      afull_ff  <= (count_nxt >= CW'(AFULL_THRESH));
      aempty_ff <= (count_nxt <= CW'(AEMPTY_THRESH));
    end
  end

  // Sticky errors: a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_ff  <= 1'b0;
      underflow_ff <= 1'b0;
    end else begin
      overflow_ff  <= ovf_set | (overflow_ff & ~err_clr);
      underflow_ff <= unf_set | (underflow_ff & ~err_clr);
    end
  end

endmodule

// File: tb/tb_fifo_cntl_ext.sv
// Scoreboard bench for fifo_cntl_ext: NUM_ENTRIES=5 with and without bypass.
module tb_fifo_cntl_ext;

  typedef struct {
    bit       sel;
    bit       we;
    bit       byp;
    int       wa;
    int       ra;
    int       cnt;
    bit [5:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic push_a = 1'b0, pop_a = 1'b0, flush_a = 1'b0, clr_a = 1'b0;
  logic push_b = 1'b0, pop_b = 1'b0, flush_b = 1'b0, clr_b = 1'b0;

  logic       we_a, byp_a, full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a;
  logic [2:0] wa_a, ra_a, cnt_a;
  logic       we_b, byp_b, full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b;
  logic [2:0] wa_b, ra_b, cnt_b;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fifo_cntl_ext #(.NUM_ENTRIES(5), .BYPASS_EN(1'b1), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .flush(flush_a), .err_clr(clr_a),
    .we(we_a), .bypass(byp_a), .waddr_ff(wa_a), .raddr_ff(ra_a), .count_ff(cnt_a),
    .full_ff(full_a), .empty_ff(empty_a), .afull_ff(afull_a), .aempty_ff(aempty_a),
    .overflow_ff(ovf_a), .underflow_ff(unf_a));

  fifo_cntl_ext #(.NUM_ENTRIES(5), .BYPASS_EN(1'b0), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .flush(flush_b), .err_clr(clr_b),
    .we(we_b), .bypass(byp_b), .waddr_ff(wa_b), .raddr_ff(ra_b), .count_ff(cnt_b),
    .full_ff(full_b), .empty_ff(empty_b), .afull_ff(afull_b), .aempty_ff(aempty_b),
    .overflow_ff(ovf_b), .underflow_ff(unf_b));

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // flg = {full, empty, afull, aempty, overflow, underflow}
  task automatic step(input bit sel, input bit p, input bit o, input bit f, input bit c,
                      input bit e_we, input bit e_byp, input int e_wa, input int e_ra,
                      input int e_cnt, input bit [5:0] e_flg);
    exp_t r;
    @(negedge clk);
    push_a = sel ? 1'b0 : p;  pop_a = sel ? 1'b0 : o;
    flush_a = sel ? 1'b0 : f; clr_a = sel ? 1'b0 : c;
    push_b = sel ? p : 1'b0;  pop_b = sel ? o : 1'b0;
    flush_b = sel ? f : 1'b0; clr_b = sel ? c : 1'b0;
    r.sel = sel; r.we = e_we; r.byp = e_byp; r.wa = e_wa; r.ra = e_ra;
    r.cnt = e_cnt; r.flg = e_flg;
    q.push_back(r);
  endtask

  task automatic idle();
    @(negedge clk);
    push_a = 0; pop_a = 0; flush_a = 0; clr_a = 0;
    push_b = 0; pop_b = 0; flush_b = 0; clr_b = 0;
  endtask

  // Monitor: combinational outputs just before the edge, registered ones just after.
  initial begin
    exp_t r;
    forever begin
      @(posedge clk);
      if (q.size() > 0) begin
        r = q.pop_front();
        if (!r.sel) begin
          chk("we", int'(we_a), int'(r.we));
          chk("bypass", int'(byp_a), int'(r.byp));
        end else begin
          chk("we_nb", int'(we_b), int'(r.we));
          chk("bypass_nb", int'(byp_b), int'(r.byp));
        end
        #1;
        if (!r.sel) begin
          chk("waddr", int'(wa_a), r.wa);
          chk("raddr", int'(ra_a), r.ra);
          chk("count", int'(cnt_a), r.cnt);
          chk("flags", int'({full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a}), int'(r.flg));
        end else begin
          chk("waddr_nb", int'(wa_b), r.wa);
          chk("raddr_nb", int'(ra_b), r.ra);
          chk("count_nb", int'(cnt_b), r.cnt);
          chk("flags_nb", int'({full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b}), int'(r.flg));
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
  endtask

  initial begin
    push_a = 1'b1;
    #12;
    chk("rst_we", int'(we_a), 1);
    chk("rst_bypass", int'(byp_a), 0);
    chk("rst_waddr", int'(wa_a), 0);
    chk("rst_raddr", int'(ra_a), 0);
    chk("rst_count", int'(cnt_a), 0);
    chk("rst_flags", int'({full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a}), 'b010100);
    @(negedge clk);
    push_a = 1'b0;
    rst_n = 1'b1;

    // fill to full, then overflow
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 6'b000100);
    step(0, 1, 0, 0, 0, 1, 0, 2, 0, 2, 6'b000000);
    step(0, 1, 0, 0, 0, 1, 0, 3, 0, 3, 6'b000000);
    step(0, 1, 0, 0, 0, 1, 0, 4, 0, 4, 6'b001000);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 5, 6'b101000);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 5, 6'b101010);
    // drain to empty, then underflow
    step(0, 0, 1, 0, 0, 0, 0, 0, 1, 4, 6'b001010);
    step(0, 0, 1, 0, 0, 0, 0, 0, 2, 3, 6'b000010);
    step(0, 0, 1, 0, 0, 0, 0, 0, 3, 2, 6'b000010);
    step(0, 0, 1, 0, 0, 0, 0, 0, 4, 1, 6'b000110);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b010110);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 6'b010111);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b010100);
    // bypass while empty
    step(0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 6'b010100);
    // simultaneous push/pop at count 3
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 6'b000100);
    step(0, 1, 0, 0, 0, 1, 0, 2, 0, 2, 6'b000000);
    step(0, 1, 0, 0, 0, 1, 0, 3, 0, 3, 6'b000000);
    step(0, 1, 1, 0, 0, 1, 0, 4, 1, 3, 6'b000000);
    step(0, 1, 0, 0, 0, 1, 0, 0, 1, 4, 6'b001000);
    step(0, 1, 0, 0, 0, 1, 0, 1, 1, 5, 6'b101000);
    step(0, 1, 0, 0, 0, 0, 0, 1, 1, 5, 6'b101010);
    // push+pop while full: push dropped, pop taken
    step(0, 1, 1, 0, 0, 0, 0, 1, 2, 4, 6'b001010);
    // flush keeps error flags; we suppressed
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 6'b010110);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b010100);
    // clear and new error in the same cycle: error wins
    step(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 6'b010101);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 6'b010100);
    // no-bypass instance: push+pop while empty
    step(1, 1, 1, 0, 0, 1, 0, 1, 0, 1, 6'b000101);
    // build state for the async reset
    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 6'b000100);
    step(0, 1, 0, 0, 0, 1, 0, 2, 0, 2, 6'b000000);
    idle();
    drain();

    @(negedge clk);
    push_a = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_waddr", int'(wa_a), 0);
    chk("async_count", int'(cnt_a), 0);
    chk("async_flags", int'({full_a, empty_a, afull_a, aempty_a, ovf_a, unf_a}), 'b010100);
    chk("async_nb_count", int'(cnt_b), 0);
    chk("async_nb_flags", int'({full_b, empty_b, afull_b, aempty_b, ovf_b, unf_b}), 'b010100);
    @(negedge clk);
    push_a = 1'b0;
    rst_n = 1'b1;

    step(0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 6'b000100);
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
